// File: rtl/qos_pkg.sv
// qos_pkg: shared constants and helpers for the QoS scheduler.
//   clog2        - ceiling log2 for sizing pointers and counters
//   SCORE_W      - width of the per-channel weighted score
//   DEF_*        - default latency/reliability weights and age weight
package qos_pkg;

  localparam int unsigned SCORE_W = 24;

  // Channel 0 is the least-significant 16-bit slice.
  localparam logic [63:0] DEF_LAT_WTS = {16'd200, 16'd400, 16'd600, 16'd800};
  localparam logic [63:0] DEF_REL_WTS = {16'd210, 16'd150, 16'd95, 16'd40};
  localparam int unsigned DEF_AGE_WT  = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

endpackage

// File: rtl/qos_scheduler_if.sv
// qos_scheduler_if: packet-in / packet-out bundle of the QoS scheduler.
//   in_valid, in_ch, in_data    - packet offered by the source (no backpressure)
//   out_valid, out_ch, out_data - served packet, out_valid is a one-cycle pulse
// master: packet source / output-port side; slave: the scheduler.
interface qos_scheduler_if #(
  parameter int unsigned CH_W   = 2,
  parameter int unsigned DATA_W = 2
);
  logic              in_valid;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [CH_W-1:0]   out_ch;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ch, in_data,
    input  out_valid, out_ch, out_data
  );

  modport slave (
    input  in_valid, in_ch, in_data,
    output out_valid, out_ch, out_data
  );
endinterface

// File: rtl/qos_queue.sv
// qos_queue: circular drop-oldest FIFO, DEPTH need not be a power of two.
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   push/push_data - append; when full and not popping, the oldest entry is dropped
//   pop            - remove head (ignored when empty); applied before a same-cycle push
//   head           - oldest entry
//   occ/full/empty - fill level and flags
module qos_queue
  import qos_pkg::*;
#(
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned DATA_W = 2,
  parameter int unsigned OCC_W  = clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] head,
  output logic [OCC_W-1:0]  occ,
  output logic              full,
  output logic              empty
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [OCC_W-1:0]  occ_q;
  logic              do_pop, advance_head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full   = (occ_q == OCC_W'(DEPTH));
  assign empty  = (occ_q == '0);
  assign do_pop = pop && !empty;
  // A push into a full queue discards the head exactly like a pop would.
  assign advance_head = do_pop || (push && full);

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push)         tail_q <= next_ptr(tail_q);
      if (advance_head) head_q <= next_ptr(head_q);
      if (push && !advance_head)  occ_q <= occ_q + 1'b1;
      else if (!push && do_pop)   occ_q <= occ_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[tail_q] <= push_data;
  end

  assign head = mem_q[head_q];
  assign occ  = occ_q;

endmodule

// File: rtl/qos_scheduler.sv
// qos_scheduler: NUM_CH drop-oldest queues, one packet served per service tick
// from the channel with the highest score LAT_WTS[c] + REL_WTS[c]*occ[c].
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   bus (slave)   - packet in (in_valid/in_ch/in_data), packet out (out_*)
//   occupancy     - per-channel fill level, OCC_W bits each
//   received_cnt, dropped_cnt, served_cnt - saturating per-channel counters
// Optional: define QOS_AGING_EN to add AGE_WT*age[c] to each score, where age
// counts ticks a non-empty channel went unserved.
module qos_scheduler
  import qos_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned DATA_W = 2,
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned PERIOD = 150000000,
`ifdef QOS_AGING_EN
  parameter int unsigned AGE_WT = DEF_AGE_WT,
`endif
  parameter logic [NUM_CH*16-1:0] LAT_WTS = DEF_LAT_WTS,
  parameter logic [NUM_CH*16-1:0] REL_WTS = DEF_REL_WTS,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1,
  localparam int unsigned OCC_W = clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  qos_scheduler_if.slave           bus,
  output logic [NUM_CH*OCC_W-1:0]  occupancy,
  output logic [NUM_CH*CNT_W-1:0]  received_cnt,
  output logic [NUM_CH*CNT_W-1:0]  dropped_cnt,
  output logic [NUM_CH*CNT_W-1:0]  served_cnt
);
  localparam int unsigned TICK_W = clog2(PERIOD);

  logic [TICK_W-1:0] tick_cnt_q;
  logic              tick;

  logic [DATA_W-1:0] q_head [NUM_CH];
  logic [OCC_W-1:0]  q_occ  [NUM_CH];
  logic [NUM_CH-1:0] q_full, q_empty, q_push, q_pop;

  logic              push_ok, any_elig;
  logic [CH_W-1:0]   win;

  logic [CNT_W-1:0]  recv_q [NUM_CH];
  logic [CNT_W-1:0]  drop_q [NUM_CH];
  logic [CNT_W-1:0]  serv_q [NUM_CH];

  logic              out_valid_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [DATA_W-1:0] out_data_q;

`ifdef QOS_AGING_EN
  logic [7:0] age_q [NUM_CH];
`endif

  // Service tick timer
  assign tick = (tick_cnt_q == TICK_W'(PERIOD - 1));

  always_ff @(posedge clock) begin
    if (reset || tick) tick_cnt_q <= '0;
    else               tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // Scoring and arbitration on pre-update occupancy; strict '>' keeps ties
  // on the lowest channel index.
  always_comb begin
    logic [SCORE_W-1:0] score, best;
    best     = '0;
    win      = '0;
    any_elig = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      score = SCORE_W'(LAT_WTS[c*16 +: 16])
            + SCORE_W'(REL_WTS[c*16 +: 16]) * SCORE_W'(q_occ[c]);
`ifdef QOS_AGING_EN
      score = score + SCORE_W'(AGE_WT) * SCORE_W'(age_q[c]);
`endif
      if (!q_empty[c] && (!any_elig || score > best)) begin
        any_elig = 1'b1;
        best     = score;
        win      = CH_W'(c);
      end
    end
  end

  assign push_ok = bus.in_valid && (32'(bus.in_ch) < NUM_CH);

  always_comb begin
    q_push = '0;
    q_pop  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      q_push[c] = push_ok && (bus.in_ch == CH_W'(c));
      q_pop[c]  = tick && any_elig && (win == CH_W'(c));
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    qos_queue #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .OCC_W  (OCC_W)
    ) u_queue (
      .clock     (clock),
      .reset     (reset),
      .push      (q_push[c]),
      .pop       (q_pop[c]),
      .push_data (bus.in_data),
      .head      (q_head[c]),
      .occ       (q_occ[c]),
      .full      (q_full[c]),
      .empty     (q_empty[c])
    );

    assign occupancy[c*OCC_W +: OCC_W]    = q_occ[c];
    assign received_cnt[c*CNT_W +: CNT_W] = recv_q[c];
    assign dropped_cnt[c*CNT_W +: CNT_W]  = drop_q[c];
    assign served_cnt[c*CNT_W +: CNT_W]   = serv_q[c];
  end

  // Saturating statistics; a full queue popped on the same tick does not drop.
  always_ff @(posedge clock) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        recv_q[c] <= '0;
        drop_q[c] <= '0;
        serv_q[c] <= '0;
      end else begin
        if (q_push[c] && recv_q[c] != '1) recv_q[c] <= recv_q[c] + 1'b1;
        if (q_push[c] && q_full[c] && !q_pop[c] && drop_q[c] != '1)
          drop_q[c] <= drop_q[c] + 1'b1;
        if (q_pop[c] && serv_q[c] != '1) serv_q[c] <= serv_q[c] + 1'b1;
      end
    end
  end

`ifdef QOS_AGING_EN
  always_ff @(posedge clock) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        age_q[c] <= '0;
      end else if (tick) begin
        if (q_pop[c] || q_empty[c]) age_q[c] <= '0;
        else if (age_q[c] != '1)    age_q[c] <= age_q[c] + 1'b1;
      end
    end
  end
`endif

  // Served packet appears the cycle after the tick; ch/data hold otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= tick && any_elig;
      if (tick && any_elig) begin
        out_ch_q   <= win;
        out_data_q <= q_head[win];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: doc/qos_scheduler.md
Name: qos_scheduler

Overview:
- Parametrised successor to the four-buffer QoS container.
- Accepts tagged packets into NUM_CH per-channel drop-oldest queues of DEPTH entries.
- On every service tick, emits one packet from the channel with the highest weighted score: latency weight plus reliability weight times occupancy.
- Sits between the packet source and the downstream output port. Exports per-channel statistics.

Parameters:
- NUM_CH, 4: number of channels/queues; CH_W = clog2(NUM_CH).
- DEPTH, 6: entries per queue; OCC_W = clog2(DEPTH+1).
- DATA_W, 2: payload width.
- CNT_W, 12: width of statistics counters.
- PERIOD, 150000000: clock cycles per service tick; must be ≥2.
- LAT_WTS, {16'd200,16'd400,16'd600,16'd800}: packed 16-bit latency weights; channel 0 is the LSB slice (800).
- REL_WTS, {16'd210,16'd150,16'd95,16'd40}: packed 16-bit reliability weights; channel 0 is the LSB slice (40).

Ports:
- clock, in, 1: single clock, all logic on the rising edge.
- reset, in, 1: synchronous, active-high.
- in_valid, in, 1: one packet offered this cycle. There is no backpressure; a packet is always accepted or replaces the oldest entry.
- in_ch, in, CH_W: destination channel.
- in_data, in, DATA_W: payload.
- out_valid, out, 1: one-cycle pulse, served packet present.
- out_ch, out, CH_W: channel served.
- out_data, out, DATA_W: served payload.
- occupancy, out, NUM_CH*OCC_W: per-channel fill level.
- received_cnt, out, NUM_CH*CNT_W: packets received per channel.
- dropped_cnt, out, NUM_CH*CNT_W: packets dropped per channel.
- served_cnt, out, NUM_CH*CNT_W: packets served per channel.

Behaviour:
- Reset: all queues empty; occupancy, all counters, tick counter, out_valid, out_ch and out_data are 0. Reset mid-operation discards all queued data. No pending output survives reset.
- Tick counter: counts 0..PERIOD-1. The tick cycle is count==PERIOD-1; the counter then wraps to 0.
- Push, any cycle, when in_valid and in_ch<NUM_CH:
  - Increment received_cnt[in_ch].
  - If the queue is not full, append the packet.
  - If the queue is full, discard the head (oldest), append the new packet, increment dropped_cnt. Occupancy is unchanged.
- Pushes with in_ch≥NUM_CH are ignored with no counter change.
- Score (tick cycle, combinational, uses pre-update occupancy): score_c = LAT_WTS[c] + REL_WTS[c]*occ_c, 24-bit unsigned, no overflow.
  - Channels with occ_c==0 are ineligible.
  - The highest score wins; ties go to the lowest channel index.
  - If no channel is eligible, nothing is served.
- Serve: on the tick cycle the winner's head is popped and served_cnt is incremented. On the next cycle out_valid=1, out_ch=winner, out_data=popped head. out_valid returns to 0 the cycle after.
- out_ch and out_data hold their last value while out_valid=0.
- Same-channel push and pop on the tick cycle: pop first, then append. A full queue therefore does not drop, and its occupancy is unchanged.
- A push into an empty queue on the tick cycle is not eligible for that tick.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Queue storage is a circular buffer with head/tail pointers wrapping at DEPTH; DEPTH need not be a power of two.

Optional Feature:
- Macro: QOS_AGING_EN.
- Defined:
  - Each channel keeps an 8-bit saturating age counter, incremented on every tick at which the channel is non-empty and not served.
  - The age counter clears when the channel is served or becomes empty, and on reset.
  - score_c gains + AGE_WT*age_c; AGE_WT is a parameter, default 16.
  - This guarantees low-weight channels are eventually served.
- Undefined: no age state; score as above.

Decomposition:
- Package qos_pkg holds:
  - the clog2 function;
  - score width constant SCORE_W=24;
  - default weight constants;
  - the AGE_WT default.
- Sub-module qos_queue (one instance per channel): circular drop-oldest FIFO with push, pop, push-while-full and simultaneous push/pop. It outputs head, occupancy, full and empty.
- Scoring, arbitration, tick counter and statistics stay in qos_scheduler.

Test Plan:
1. PERIOD=8. After reset, push ch1 data 3 at cycle 2 → tick at cycle 7; out_valid at cycle 8 with out_ch=1, out_data=3; served_cnt[1]=1, occupancy[1]=0.
2. DEPTH=6. Push ch0 data 0,1,2,3,0,1,2 before the tick → received_cnt[0]=7, dropped_cnt[0]=1, occupancy[0]=6; first served data=1.
3. ch0 occ=1 (840) vs ch3 occ=3 (830) → ch0 served. Repeat with ch0 occ=1 vs ch3 occ=4 (1040) → ch3 served.
4. LAT_WTS all 100, REL_WTS all 10; ch1 and ch2 each occ=1 → tie, ch1 served; then ch2 at the next tick.
5. ch2 full (6) and sole non-empty channel; push ch2 on the tick cycle → dropped_cnt[2] unchanged, occupancy[2] stays 6, served_cnt[2]+1.
6. Reset asserted mid-period with occupancy[0]=3 → next cycle all outputs 0; no out_valid at the following tick. With QOS_AGING_EN, ch0 starved for 3 ticks shows age=3 in its score.
